// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the 8-bit pipelined processor front end.
// Holds opcode encodings, the stack-pointer register index, the decode FSM
// encoding, operand-select codes and the decoded-control / ID-EX payload types.
package proc_pkg;

   localparam int unsigned XLEN = 8;   // datapath width
   localparam int unsigned OPW  = 4;   // opcode field width, instr[7:4]
   localparam int unsigned RAW  = 2;   // register address width

   localparam logic [OPW-1:0] OP_NOP  = 4'd0;
   localparam logic [OPW-1:0] OP_MOV  = 4'd1;
   localparam logic [OPW-1:0] OP_ADD  = 4'd2;
   localparam logic [OPW-1:0] OP_SUB  = 4'd3;
   localparam logic [OPW-1:0] OP_AND  = 4'd4;
   localparam logic [OPW-1:0] OP_OR   = 4'd5;
   localparam logic [OPW-1:0] OP_PUSH = 4'd6;
   localparam logic [OPW-1:0] OP_POP  = 4'd7;
   localparam logic [OPW-1:0] OP_LDM  = 4'd8;
   localparam logic [OPW-1:0] OP_LDD  = 4'd9;
   localparam logic [OPW-1:0] OP_STD  = 4'd10;

   localparam logic [RAW-1:0] SP_IDX = 2'd3;

   // Decode FSM: DEC decodes opcodes, IMM expects the LDM immediate byte
   typedef enum logic {
      ST_DEC = 1'b0,
      ST_IMM = 1'b1
   } id_state_e;

   // Operand source selection produced by the decoder
   typedef enum logic [2:0] {
      SEL_ZERO   = 3'd0,
      SEL_RA     = 3'd1,
      SEL_RB     = 3'd2,
      SEL_SP     = 3'd3,
      SEL_SP_INC = 3'd4
   } opnd_sel_e;

   typedef struct packed {
      logic           wr;
      logic           mrd;
      logic           mwr;
      logic [RAW-1:0] dest;
   } id_ctl_t;

   typedef struct packed {
      logic [OPW-1:0] op;       // opcode as issued (NOP for reserved)
      id_ctl_t        ctl;
      opnd_sel_e      sel_a;
      opnd_sel_e      sel_b;
      logic           use_ra;   // source register usage for hazard checks
      logic           use_rb;
      logic           use_sp;
      logic           sp_op;    // PUSH or POP
      logic           is_ldm;
      logic           illegal;
   } id_dec_t;

   // ID/EX pipeline register payload
   typedef struct packed {
      logic            valid;
      logic [OPW-1:0]  op;
      logic [XLEN-1:0] op_a;
      logic [XLEN-1:0] op_b;
      id_ctl_t         ctl;
      logic            illegal;
   } ex_reg_t;

   function automatic logic is_sp_op(input logic [OPW-1:0] op);
      return (op == OP_PUSH) || (op == OP_POP);
   endfunction

endpackage

// File: rtl/id_decoder.sv
// id_decoder: combinational opcode-to-control lookup.
// Ports:
//   instr  in   8  instruction byte (op = instr[7:4], ra = [3:2], rb = [1:0])
//   dec    out     decoded controls, operand selects and source-usage flags
module id_decoder
   import proc_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   output id_dec_t         dec
);

   logic [OPW-1:0] op;
   logic [RAW-1:0] ra;

   assign op = instr[XLEN-1 -: OPW];
   assign ra = instr[2*RAW-1 -: RAW];

   // Opcode table; reserved opcodes collapse to NOP with the illegal flag
   always_comb begin
      dec          = '0;
      dec.op       = op;
      dec.sel_a    = SEL_ZERO;
      dec.sel_b    = SEL_ZERO;
      case (op)
         OP_NOP: ;
         OP_MOV: begin
            dec.sel_a    = SEL_RB;
            dec.sel_b    = SEL_RB;
            dec.ctl.dest = ra;
            dec.ctl.wr   = 1'b1;
            dec.use_rb   = 1'b1;
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            dec.sel_a    = SEL_RA;
            dec.sel_b    = SEL_RB;
            dec.ctl.dest = ra;
            dec.ctl.wr   = 1'b1;
            dec.use_ra   = 1'b1;
            dec.use_rb   = 1'b1;
         end
         OP_PUSH: begin
            dec.sel_a    = SEL_SP;
            dec.sel_b    = SEL_RB;
            dec.ctl.dest = SP_IDX;
            dec.ctl.wr   = 1'b1;
            dec.ctl.mwr  = 1'b1;
            dec.use_rb   = 1'b1;
            dec.use_sp   = 1'b1;
            dec.sp_op    = 1'b1;
         end
         OP_POP: begin
            dec.sel_a    = SEL_SP_INC;
            dec.ctl.dest = ra;
            dec.ctl.wr   = 1'b1;
            dec.ctl.mrd  = 1'b1;
            dec.use_sp   = 1'b1;
            dec.sp_op    = 1'b1;
         end
         OP_LDM: begin
            dec.ctl.dest = ra;
            dec.ctl.wr   = 1'b1;
            dec.is_ldm   = 1'b1;
         end
         OP_LDD: begin
            dec.sel_a    = SEL_RB;
            dec.ctl.dest = ra;
            dec.ctl.wr   = 1'b1;
            dec.ctl.mrd  = 1'b1;
            dec.use_rb   = 1'b1;
         end
         OP_STD: begin
            dec.sel_a    = SEL_RA;
            dec.sel_b    = SEL_RB;
            dec.ctl.mwr  = 1'b1;
            dec.use_ra   = 1'b1;
            dec.use_rb   = 1'b1;
         end
         default: begin
            dec.op      = OP_NOP;
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage plus ID/EX pipeline register.
// Optional feature macro: ID_WB_BYPASS_EN (writeback-to-read bypass).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_valid, if_instr, id_ready     instruction byte handshake
//   flush, ex_hold                   pipeline kill / downstream freeze
//   rf_ra, rf_rb                     register-file read addresses (comb)
//   rf_rd1, rf_rd2, rf_sp            register-file read data and SP
//   sp_inc                           SP increment pulse when a POP is accepted
//   wb_wr_en, wb_addr, wb_data       writeback port, used only for bypass
//   ex_valid .. ex_illegal           registered micro-op to EX
module id_ex_stage
   import proc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [XLEN-1:0]  if_instr,
   output logic             id_ready,
   input  logic             flush,
   input  logic             ex_hold,
   output logic [RAW-1:0]   rf_ra,
   output logic [RAW-1:0]   rf_rb,
   input  logic [XLEN-1:0]  rf_rd1,
   input  logic [XLEN-1:0]  rf_rd2,
   input  logic [XLEN-1:0]  rf_sp,
   output logic             sp_inc,
   input  logic             wb_wr_en,
   input  logic [RAW-1:0]   wb_addr,
   input  logic [XLEN-1:0]  wb_data,
   output logic             ex_valid,
   output logic [OPW-1:0]   ex_op,
   output logic [XLEN-1:0]  ex_op_a,
   output logic [XLEN-1:0]  ex_op_b,
   output logic [RAW-1:0]   ex_dest,
   output logic             ex_reg_wr,
   output logic             ex_mem_rd,
   output logic             ex_mem_wr,
   output logic             ex_illegal
);

   id_state_e       state, state_nxt;
   logic [RAW-1:0]  ldm_ra, ldm_ra_nxt;
   ex_reg_t         ex_q, ex_d;
   logic            ex_load;
   id_dec_t         dec;
   logic [XLEN-1:0] rd_a, rd_b, sp_val;
   logic            ld_hit, sp_hit, stall, accept;

   assign rf_ra = if_instr[2*RAW-1 -: RAW];
   assign rf_rb = if_instr[RAW-1:0];

   id_decoder u_dec (
      .instr (if_instr),
      .dec   (dec)
   );

`ifdef ID_WB_BYPASS_EN
   // Same-edge writeback: forward wb_data over stale register-file reads
   always_comb begin
      rd_a   = (wb_wr_en && (wb_addr == rf_ra))  ? wb_data : rf_rd1;
      rd_b   = (wb_wr_en && (wb_addr == rf_rb))  ? wb_data : rf_rd2;
      sp_val = (wb_wr_en && (wb_addr == SP_IDX)) ? wb_data : rf_sp;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_wr_en, wb_addr, wb_data};
   assign rd_a      = rf_rd1;
   assign rd_b      = rf_rd2;
   assign sp_val    = rf_sp;
`endif

   // Hazards only apply when an opcode byte is being decoded
   always_comb begin
      ld_hit = ex_q.valid && ex_q.ctl.mrd &&
               ((dec.use_ra && (ex_q.ctl.dest == rf_ra)) ||
                (dec.use_rb && (ex_q.ctl.dest == rf_rb)) ||
                (dec.use_sp && (ex_q.ctl.dest == SP_IDX)));
      sp_hit = dec.sp_op && ex_q.valid && is_sp_op(ex_q.op);
      stall  = (state == ST_DEC) && if_valid && (ld_hit || sp_hit);
   end

   assign id_ready = !rst && !flush && !ex_hold && !stall;
   assign accept   = if_valid && id_ready;
   assign sp_inc   = accept && (state == ST_DEC) && (dec.op == OP_POP);

   function automatic logic [XLEN-1:0] pick(input opnd_sel_e       sel,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b,
                                            input logic [XLEN-1:0] sp);
      logic [XLEN-1:0] v;
      case (sel)
         SEL_RA:     v = a;
         SEL_RB:     v = b;
         SEL_SP:     v = sp;
         SEL_SP_INC: v = XLEN'(sp + XLEN'(1));
         default:    v = '0;
      endcase
      return v;
   endfunction

   // Next state and ID/EX load; priority flush > ex_hold > stall
   always_comb begin
      state_nxt  = state;
      ldm_ra_nxt = ldm_ra;
      ex_load    = 1'b1;
      ex_d       = '0;
      if (flush) begin
         state_nxt = ST_DEC;
      end else if (ex_hold) begin
         ex_load = 1'b0;
      end else if (accept) begin
         if (state == ST_IMM) begin
            ex_d.valid    = 1'b1;
            ex_d.op       = OP_LDM;
            ex_d.op_a     = if_instr;
            ex_d.op_b     = if_instr;
            ex_d.ctl.dest = ldm_ra;
            ex_d.ctl.wr   = 1'b1;
            state_nxt     = ST_DEC;
         end else if (dec.is_ldm) begin
            // first LDM byte: remember destination, bubble to EX
            ldm_ra_nxt = rf_ra;
            state_nxt  = ST_IMM;
         end else begin
            ex_d.valid   = 1'b1;
            ex_d.op      = dec.op;
            ex_d.op_a    = pick(dec.sel_a, rd_a, rd_b, sp_val);
            ex_d.op_b    = pick(dec.sel_b, rd_a, rd_b, sp_val);
            ex_d.ctl     = dec.ctl;
            ex_d.illegal = dec.illegal;
         end
      end
   end

   // State and ID/EX register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_DEC;
         ldm_ra <= '0;
         ex_q   <= '0;
      end else begin
         state  <= state_nxt;
         ldm_ra <= ldm_ra_nxt;
         if (ex_load) begin
            ex_q <= ex_d;
         end
      end
   end

   assign ex_valid   = ex_q.valid;
   assign ex_op      = ex_q.op;
   assign ex_op_a    = ex_q.op_a;
   assign ex_op_b    = ex_q.op_b;
   assign ex_dest    = ex_q.ctl.dest;
   assign ex_reg_wr  = ex_q.ctl.wr;
   assign ex_mem_rd  = ex_q.ctl.mrd;
   assign ex_mem_wr  = ex_q.ctl.mwr;
   assign ex_illegal = ex_q.illegal;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 8-bit pipelined processor.
- Consumes fetched instruction bytes and drives the register-file read addresses.
- Captures register-file read data and SP, and issues a decoded micro-op to EX.
- Handles two-byte LDM, load-use and SP hazards, POP's SP increment, flush and downstream hold.

Parameters:
- OPW, 4, opcode field width (instr[7:4]); ra = instr[3:2], rb = instr[1:0]
- SP_IDX, 3, register index used as stack pointer

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- if_valid  in  1  instruction byte valid
- if_instr  in  8  instruction byte
- id_ready  out  1  byte accepted this cycle when if_valid && id_ready
- flush  in  1  kill in-flight decode and ID/EX contents
- ex_hold  in  1  EX stalled; freeze ID/EX register
- rf_ra  out  2  register-file read address A (= instr ra)
- rf_rb  out  2  register-file read address B (= instr rb)
- rf_rd1  in  8  read data A
- rf_rd2  in  8  read data B
- rf_sp  in  8  current SP
- sp_inc  out  1  one-cycle SP increment pulse to register file
- wb_wr_en  in  1  writeback write enable (bypass only)
- wb_addr  in  2  writeback register address (bypass only)
- wb_data  in  8  writeback data (bypass only)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_op  out  4  opcode passed to EX
- ex_op_a  out  8  operand A
- ex_op_b  out  8  operand B
- ex_dest  out  2  destination register
- ex_reg_wr  out  1  writes a register
- ex_mem_rd  out  1  memory read
- ex_mem_wr  out  1  memory write
- ex_illegal  out  1  reserved opcode seen (issued as NOP)

Behaviour:
- Reset: all ex_* outputs 0, sp_inc 0, FSM = DEC, held immediate-op state cleared. id_ready is 0 during the reset cycle.
- Opcode map and decode (columns: op_a / op_b / dest / wr / mrd / mwr):
  - 0 NOP: 0 / 0 / 0 / 0 / 0 / 0
  - 1 MOV: R[rb] / R[rb] / ra / 1 / 0 / 0
  - 2 ADD, 3 SUB, 4 AND, 5 OR: R[ra] / R[rb] / ra / 1 / 0 / 0
  - 6 PUSH: SP / R[rb] / SP_IDX / 1 / 0 / 1 (EX computes SP-1)
  - 7 POP: SP+1 (mod 256) / 0 / ra / 1 / 1 / 0; sp_inc = 1 in the issue cycle
  - 8 LDM: imm / imm / ra / 1 / 0 / 0
  - 9 LDD: R[rb] / 0 / ra / 1 / 1 / 0
  - 10 STD: R[ra] / R[rb] / 0 / 0 / 0 / 1
  - 11-15: issued as NOP with ex_illegal = 1
- FSM states:
  - DEC: accepting LDM latches ra and moves to IMM. A bubble goes to ID/EX.
  - IMM: the next accepted byte is the immediate. LDM then issues and the FSM returns to DEC.
  - A byte in IMM is never decoded as an opcode.
- Latency: an accepted byte issues at the next rising edge. ex_* is valid in the following cycle.
- Load-use stall: ID/EX holds ex_mem_rd with ex_dest equal to a register read by the current instruction.
  - Response: id_ready = 0, bubble inserted, instruction retried next cycle.
  - Source registers:
    - MOV, LDD: rb
    - ALU ops, STD: ra and rb
    - PUSH: rb and SP
    - POP: SP
- SP stall: current instruction is PUSH or POP while ID/EX holds PUSH or POP. Stall one cycle.
- ex_hold: ID/EX frozen, id_ready = 0, sp_inc = 0. The FSM holds state.
- flush:
  - ID/EX becomes a bubble, FSM goes to DEC, the held LDM is dropped.
  - id_ready = 0 and sp_inc = 0 in that cycle.
  - Priority: rst > flush > ex_hold > hazard stall.
- sp_inc pulses only when a POP is actually accepted: not stalled, not held, not flushed.
- if_valid = 0: bubble issued, unless ex_hold is asserted.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: when wb_wr_en && wb_addr equals a read address in the same cycle, wb_data replaces rf_rd1, rf_rd2 or rf_sp. This covers same-edge write/read.
- Undefined: wb_* ports remain, are ignored, and raw register-file data is used.

Decomposition:
- Shared package proc_pkg:
  - opcode localparams OP_NOP through OP_STD
  - SP_IDX
  - FSM state encoding
  - decoded-control struct/typedef (wr, mrd, mwr, dest)
- Sub-module id_decoder: combinational opcode-to-control lookup plus source-register-usage flags, instantiated once.

Test Plan:
- ADD R1,R2 (0x26), R1=5, R2=7 -> next cycle ex_op=2, op_a=5, op_b=7, dest=1, reg_wr=1.
- LDM R2 then 0x3C -> first cycle is a bubble; then ex_op=8, op_a=0x3C, dest=2; 0x3C never decoded as an opcode.
- LDD R1,[R0] followed by ADD R1,R1 -> one bubble with id_ready=0, then ADD issues.
- POP R0 with SP=0xFE -> sp_inc single pulse, op_a=0xFF, mem_rd=1. SP=0xFF -> op_a=0x00.
- PUSH then POP back-to-back -> one SP stall cycle, sp_inc only when POP issues.
- flush while in IMM, and rst mid-stall -> bubble, FSM=DEC, no sp_inc. With ID_WB_BYPASS_EN, wb write R2=0x99 during a read of R2 -> op_b=0x99.
